idli_insn_buf_m: RTL and testbench
==================================

Name: idli_insn_buf_m

Overview:
Parametrised instruction front-end buffer that sits between the SQI/OPI memory interface and the decoder. It deserialises LANE_W-bit beats, MSB first, into INSN_W-bit instruction words. It detects when a trailing immediate word follows and captures it into the same entry. Complete entries are queued in a DEPTH-entry FIFO with a valid/ready handshake to decode, and the FIFO flushes on execute redirect.

Parameters:
LANE_W, 4, bits per input beat; legal values 4 (SQI) or 8 (OPI).
INSN_W, 16, instruction and immediate width; must be a multiple of LANE_W.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
i_ib_gck  input  1  clock
i_ib_rst  input  1  reset, synchronous, active-high
i_ib_data  input  LANE_W  instruction-stream beat, MSB-first within each word
i_ib_data_vld  input  1  beat valid
o_ib_data_rdy  output  1  beat accepted when i_ib_data_vld && o_ib_data_rdy
o_ib_insn  output  INSN_W  head-entry instruction
o_ib_imm  output  INSN_W  head-entry immediate
o_ib_imm_vld  output  1  head entry carries an immediate
o_ib_vld  output  1  head entry valid
i_ib_rdy  input  1  decode consumes head when o_ib_vld && i_ib_rdy
i_ib_flush  input  1  execute redirect; discard everything
o_ib_count  output  $clog2(DEPTH+1)  occupied entries
o_ib_busy  output  1  assembler is mid-word

Behaviour:
- Clocking: one clock, i_ib_gck. Reset is synchronous and active-high on i_ib_rst.
- Reset values: o_ib_vld=0, o_ib_count=0, o_ib_data_rdy=1, o_ib_busy=0. o_ib_insn, o_ib_imm and o_ib_imm_vld are 0.
- Empty gating: o_ib_insn, o_ib_imm and o_ib_imm_vld are forced to 0 whenever o_ib_vld=0.
- BEATS = INSN_W/LANE_W. A beat counter runs 0..BEATS-1.
- Assembler states:
  - ASM_INSN: accepted beats shift into an insn register; on beat BEATS-1 the word is complete.
  - ASM_IMM: accepted beats shift into an imm register.
- Immediate rule, evaluated on the completed word W: HAS_IMM = (W[2:0]==3'b111) && !(W[15:12]==4'b1011 && W[11]). The second term exempts INC/DEC/URX, whose C field selects UART.
- Transitions:
  - ASM_INSN, last beat, HAS_IMM: go to ASM_IMM, counter=0, no push.
  - ASM_INSN, last beat, !HAS_IMM: push {W, 0, imm_vld=0}; stay in ASM_INSN.
  - ASM_IMM, last beat: push {W_held, imm, imm_vld=1}; return to ASM_INSN.
- o_ib_busy=1 whenever the counter is nonzero or the state is ASM_IMM.
- o_ib_data_rdy = (count < DEPTH). It is registered and has no combinational path from i_ib_rdy. Beats are accepted only on rdy, including mid-word beats. A push can therefore never overflow.
- Pop: occurs when o_ib_vld && i_ib_rdy. Push and pop in the same cycle leave count unchanged; when count==0 the cycle is a push only.
- Latency: an entry is visible on o_ib_* the cycle after its final beat is accepted. There is no bypass.
- Pointers: read and write pointers wrap modulo DEPTH.
- Priority: reset > flush > push/pop.
  - Flush clears the FIFO, sets count=0 and o_ib_vld=0, and returns the assembler to ASM_INSN with counter=0.
  - A beat presented in the flush cycle is discarded. A pop in the flush cycle has no effect beyond the flush.
  - The first beat after flush starts a fresh instruction.
- Illegal parameters (INSN_W % LANE_W != 0, or DEPTH not a power of two) produce an elaboration-time $error.

Test Plan:
1. LANE_W=4, beats C,1,2,3, i_ib_rdy=1 -> the next cycle o_ib_vld=1, insn=0xC123, imm_vld=0; the following cycle vld=0 and count=0.
2. Beats C,1,2,7,B,E,E,F -> no push after beat 4 (busy=1); after beat 8, entry insn=0xC127, imm=0xBEEF, imm_vld=1, count=1.
3. Beats B,8,1,7 (INC/URX, C=111) -> single entry insn=0xB817, imm_vld=0. The next four beats form a new instruction, not an immediate.
4. Full case: i_ib_rdy=0 and push 4 no-immediate instructions -> count=4, data_rdy=0, and held beats are not accepted. Pulse i_ib_rdy for 1 cycle -> pop 0x first entry, count=3, data_rdy=1 on the next cycle.
5. Flush mid-stream: count=2, beats C,1,2,7,B,E accepted, then i_ib_flush=1 with a beat present -> count=0, vld=0, busy=0. Then beats 0,1,2,3 -> insn=0x0123.
6. LANE_W=8: beats C1,27,BE,EF -> insn=0xC127, imm=0xBEEF. With count=1 and a push plus a pop in the same cycle, count stays 1 and the head advances.

Source files
------------

// File: rtl/idli_insn_buf_m.sv
// idli_insn_buf_m
//   Instruction front-end buffer between the SQI/OPI memory interface and
//   the decoder. LANE_W-bit beats are shifted MSB-first into INSN_W-bit
//   words; an instruction that needs a trailing immediate has the following
//   word captured into the same entry. Complete entries are queued in a
//   DEPTH-entry FIFO. The FIFO and the assembler are flushed on redirect.
//
// Ports
//   i_ib_gck       clock
//   i_ib_rst       synchronous active-high reset
//   i_ib_data      instruction-stream beat (MSB-first within a word)
//   i_ib_data_vld  beat valid
//   o_ib_data_rdy  beat accepted when valid && ready (registered)
//   o_ib_insn      head-entry instruction (0 when empty)
//   o_ib_imm       head-entry immediate (0 when empty)
//   o_ib_imm_vld   head entry carries an immediate (0 when empty)
//   o_ib_vld       head entry valid
//   i_ib_rdy       decode consumes the head when o_ib_vld && i_ib_rdy
//   i_ib_flush     execute redirect, discards everything
//   o_ib_count     occupied FIFO entries
//   o_ib_busy      assembler is part-way through a word or an immediate
module idli_insn_buf_m #(
   parameter int unsigned LANE_W = 4,
   parameter int unsigned INSN_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       i_ib_gck,
   input  logic                       i_ib_rst,
   input  logic [LANE_W-1:0]          i_ib_data,
   input  logic                       i_ib_data_vld,
   output logic                       o_ib_data_rdy,
   output logic [INSN_W-1:0]          o_ib_insn,
   output logic [INSN_W-1:0]          o_ib_imm,
   output logic                       o_ib_imm_vld,
   output logic                       o_ib_vld,
   input  logic                       i_ib_rdy,
   input  logic                       i_ib_flush,
   output logic [$clog2(DEPTH+1)-1:0] o_ib_count,
   output logic                       o_ib_busy
);

   localparam int unsigned BEATS  = INSN_W / LANE_W;
   localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   if ((INSN_W % LANE_W) != 0) begin : g_bad_width
      $error("idli_insn_buf_m: INSN_W must be a multiple of LANE_W");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("idli_insn_buf_m: DEPTH must be a power of two, at least 2");
   end

   typedef enum logic {ASM_INSN, ASM_IMM} asm_state_t;

   asm_state_t          state_q, state_d;
   logic [BCNT_W-1:0]   beat_q, beat_d;
   logic [INSN_W-1:0]   insn_q, insn_d;
   logic [INSN_W-1:0]   imm_q, imm_d;
   logic [INSN_W-1:0]   insn_shift, imm_shift;
   logic                accept, last_beat, has_imm;
   logic                push, pop;
   logic [INSN_W-1:0]   push_insn, push_imm;
   logic                push_iv;

   logic [INSN_W-1:0]   mem_insn [DEPTH];
   logic [INSN_W-1:0]   mem_imm  [DEPTH];
   logic                mem_iv   [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                data_rdy_q;

   // ---------------- assembler ----------------
   always_ff @(posedge i_ib_gck) begin
      if (i_ib_rst) begin
         state_q <= ASM_INSN;
         beat_q  <= '0;
         insn_q  <= '0;
         imm_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         insn_q  <= insn_d;
         imm_q   <= imm_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      insn_d     = insn_q;
      imm_d      = imm_q;
      push       = 1'b0;
      push_insn  = '0;
      push_imm   = '0;
      push_iv    = 1'b0;
      // A beat in the flush cycle is dropped, so flush also gates acceptance.
      accept     = i_ib_data_vld && data_rdy_q && !i_ib_flush;
      last_beat  = (beat_q == BCNT_W'(BEATS - 1));
      // Truncating the concatenation drops the oldest LANE_W bits.
      insn_shift = INSN_W'({insn_q, i_ib_data});
      imm_shift  = INSN_W'({imm_q, i_ib_data});
      // INC/DEC/URX (1011, bit 11 set) use C=111 to pick UART, not an immediate.
      has_imm    = (insn_shift[2:0] == 3'b111) &&
                   !((insn_shift[15:12] == 4'b1011) && insn_shift[11]);

      if (accept) begin
         beat_d = last_beat ? '0 : beat_q + 1'b1;
         case (state_q)
            ASM_INSN: begin
               insn_d = insn_shift;
               if (last_beat) begin
                  if (has_imm) begin
                     state_d = ASM_IMM;
                  end else begin
                     push      = 1'b1;
                     push_insn = insn_shift;
                  end
               end
            end
            ASM_IMM: begin
               imm_d = imm_shift;
               if (last_beat) begin
                  push      = 1'b1;
                  push_insn = insn_q;
                  push_imm  = imm_shift;
                  push_iv   = 1'b1;
                  state_d   = ASM_INSN;
               end
            end
            default: state_d = ASM_INSN;
         endcase
      end

      if (i_ib_flush) begin
         state_d = ASM_INSN;
         beat_d  = '0;
      end
   end

   // ---------------- FIFO ----------------
   always_comb begin
      pop = (count_q != '0) && i_ib_rdy && !i_ib_flush;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_ib_gck) begin
      if (push) begin
         mem_insn[wr_ptr] <= push_insn;
         mem_imm[wr_ptr]  <= push_imm;
         mem_iv[wr_ptr]   <= push_iv;
      end
   end

   always_ff @(posedge i_ib_gck) begin
      if (i_ib_rst || i_ib_flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         data_rdy_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q    <= count_d;
         // Registered from the next count: no path from i_ib_rdy to o_ib_data_rdy.
         data_rdy_q <= (count_d < CNT_W'(DEPTH));
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      o_ib_vld      = (count_q != '0);
      o_ib_insn     = o_ib_vld ? mem_insn[rd_ptr] : '0;
      o_ib_imm      = o_ib_vld ? mem_imm[rd_ptr]  : '0;
      o_ib_imm_vld  = o_ib_vld ? mem_iv[rd_ptr]   : 1'b0;
      o_ib_count    = count_q;
      o_ib_data_rdy = data_rdy_q;
      o_ib_busy     = (beat_q != '0) || (state_q == ASM_IMM);
   end

endmodule

// File: tb/tb_idli_insn_buf_m.sv
// Testbench for idli_insn_buf_m: an SQI (LANE_W=4) instance and an OPI
// (LANE_W=8) instance, with a scoreboard queue of expected entries per
// instance that is filled as instructions are sent and drained as decode
// consumes the head.
module tb_idli_insn_buf_m;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  d4;
   logic        d4_vld, d4_rdy, iv4, vld4, rdy4, flush4, busy4;
   logic [15:0] insn4, imm4;
   logic [2:0]  cnt4;

   logic [7:0]  d8;
   logic        d8_vld, d8_rdy, iv8, vld8, rdy8, flush8, busy8;
   logic [15:0] insn8, imm8;
   logic [2:0]  cnt8;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] insn;
      logic [15:0] imm;
      logic        iv;
   } ent_t;

   ent_t sb4[$];
   ent_t sb8[$];
   ent_t exp;

   idli_insn_buf_m #(.LANE_W(4), .INSN_W(16), .DEPTH(4)) dut4 (
      .i_ib_gck(clk), .i_ib_rst(rst), .i_ib_data(d4), .i_ib_data_vld(d4_vld),
      .o_ib_data_rdy(d4_rdy), .o_ib_insn(insn4), .o_ib_imm(imm4),
      .o_ib_imm_vld(iv4), .o_ib_vld(vld4), .i_ib_rdy(rdy4),
      .i_ib_flush(flush4), .o_ib_count(cnt4), .o_ib_busy(busy4)
   );

   idli_insn_buf_m #(.LANE_W(8), .INSN_W(16), .DEPTH(4)) dut8 (
      .i_ib_gck(clk), .i_ib_rst(rst), .i_ib_data(d8), .i_ib_data_vld(d8_vld),
      .o_ib_data_rdy(d8_rdy), .o_ib_insn(insn8), .o_ib_imm(imm8),
      .o_ib_imm_vld(iv8), .o_ib_vld(vld8), .i_ib_rdy(rdy8),
      .i_ib_flush(flush8), .o_ib_count(cnt8), .o_ib_busy(busy8)
   );

   // Present one beat and hold it until the DUT accepts it (bounded).
   task automatic beat4(input logic [3:0] d);
      logic acc;
      d4 = d; d4_vld = 1'b1;
      for (int t = 0; t < 40; t++) begin
         acc = d4_rdy;
         @(posedge clk); #1;
         if (acc) begin d4_vld = 1'b0; return; end
      end
      d4_vld = 1'b0; checks++; errors++;
      $display("FAIL beat4_accept got=timeout want=accepted");
   endtask

   task automatic beat8(input logic [7:0] d);
      logic acc;
      d8 = d; d8_vld = 1'b1;
      for (int t = 0; t < 40; t++) begin
         acc = d8_rdy;
         @(posedge clk); #1;
         if (acc) begin d8_vld = 1'b0; return; end
      end
      d8_vld = 1'b0; checks++; errors++;
      $display("FAIL beat8_accept got=timeout want=accepted");
   endtask

   task automatic word4(input logic [15:0] w);
      for (int i = 0; i < 4; i++) beat4(w[15-4*i -: 4]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d4 = '0; d4_vld = 1'b0; rdy4 = 1'b0; flush4 = 1'b0;
      d8 = '0; d8_vld = 1'b0; rdy8 = 1'b0; flush8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (vld4 !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b want=0", vld4); end
      checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", cnt4); end
      checks++; if (d4_rdy !== 1'b1) begin errors++; $display("FAIL reset_data_rdy got=%b want=1", d4_rdy); end
      checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy4); end
      checks++; if ({insn4, imm4, iv4} !== 33'd0) begin errors++; $display("FAIL reset_outputs got=%h want=0", {insn4, imm4, iv4}); end
      checks++; if ({vld8, cnt8, d8_rdy, busy8} !== 6'b0_000_1_0) begin errors++; $display("FAIL reset_opi got=%b want=000010", {vld8, cnt8, d8_rdy, busy8}); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      rdy4 = 1'b1;
      beat4(4'hC);
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", busy4); end
      beat4(4'h1); beat4(4'h2);
      sb4.push_back('{16'hC123, 16'h0000, 1'b0});
      beat4(4'h3);
      exp = sb4.pop_front();
      checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL single_head got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
      @(posedge clk); #1;
      rdy4 = 1'b0;
      checks++; if ({vld4, cnt4} !== 4'b0_000) begin errors++; $display("FAIL single_drained got=%b want=0000", {vld4, cnt4}); end
   endtask

   task automatic test_imm();
      beat4(4'hC); beat4(4'h1); beat4(4'h2); beat4(4'h7);
      checks++; if ({busy4, cnt4} !== 4'b1_000) begin errors++; $display("FAIL imm_wait got=%b want=1000", {busy4, cnt4}); end
      sb4.push_back('{16'hC127, 16'hBEEF, 1'b1});
      beat4(4'hB); beat4(4'hE); beat4(4'hE); beat4(4'hF);
      checks++; if (cnt4 !== 3'd1) begin errors++; $display("FAIL imm_count got=%0d want=1", cnt4); end
      exp = sb4.pop_front();
      checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL imm_head got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
      rdy4 = 1'b1; @(posedge clk); #1; rdy4 = 1'b0;
      checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL imm_pop got=%0d want=0", cnt4); end
   endtask

   task automatic test_uart();
      sb4.push_back('{16'hB817, 16'h0000, 1'b0});
      word4(16'hB817);
      checks++; if ({busy4, cnt4} !== 4'b0_001) begin errors++; $display("FAIL uart_push got=%b want=0001", {busy4, cnt4}); end
      sb4.push_back('{16'h0001, 16'h0000, 1'b0});
      word4(16'h0001);
      checks++; if (cnt4 !== 3'd2) begin errors++; $display("FAIL uart_next_count got=%0d want=2", cnt4); end
      for (int i = 0; i < 2; i++) begin
         exp = sb4.pop_front();
         checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL uart_head got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
         rdy4 = 1'b1; @(posedge clk); #1; rdy4 = 1'b0;
      end
      checks++; if ({vld4, insn4, imm4, iv4} !== 34'd0) begin errors++; $display("FAIL uart_empty_gate got=%h want=0", {vld4, insn4, imm4, iv4}); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         sb4.push_back('{16'h1230 + 16'(i), 16'h0000, 1'b0});
         word4(16'h1230 + 16'(i));
      end
      checks++; if ({cnt4, d4_rdy} !== 4'b100_0) begin errors++; $display("FAIL full_state got=%b want=1000", {cnt4, d4_rdy}); end
      d4 = 4'h5; d4_vld = 1'b1;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      checks++; if ({busy4, cnt4} !== 4'b0_100) begin errors++; $display("FAIL full_hold got=%b want=0100", {busy4, cnt4}); end
      d4_vld = 1'b0;
      exp = sb4.pop_front();
      checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL full_head got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
      rdy4 = 1'b1; @(posedge clk); #1; rdy4 = 1'b0;
      checks++; if ({cnt4, d4_rdy} !== 4'b011_1) begin errors++; $display("FAIL full_pop got=%b want=0111", {cnt4, d4_rdy}); end
      for (int i = 0; i < 3; i++) begin
         exp = sb4.pop_front();
         checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL full_drain got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
         rdy4 = 1'b1; @(posedge clk); #1; rdy4 = 1'b0;
      end
      checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL full_empty got=%0d want=0", cnt4); end
   endtask

   task automatic test_flush();
      sb4.push_back('{16'h1111, 16'h0000, 1'b0}); word4(16'h1111);
      sb4.push_back('{16'h2222, 16'h0000, 1'b0}); word4(16'h2222);
      checks++; if (cnt4 !== 3'd2) begin errors++; $display("FAIL flush_pre_count got=%0d want=2", cnt4); end
      beat4(4'hC); beat4(4'h1); beat4(4'h2); beat4(4'h7); beat4(4'hB); beat4(4'hE);
      d4 = 4'hF; d4_vld = 1'b1; flush4 = 1'b1; rdy4 = 1'b1;
      @(posedge clk); #1;
      flush4 = 1'b0; d4_vld = 1'b0; rdy4 = 1'b0;
      sb4.delete();
      checks++; if ({cnt4, vld4, busy4} !== 5'b000_0_0) begin errors++; $display("FAIL flush_clear got=%b want=00000", {cnt4, vld4, busy4}); end
      sb4.push_back('{16'h0123, 16'h0000, 1'b0});
      word4(16'h0123);
      checks++; if (cnt4 !== 3'd1) begin errors++; $display("FAIL flush_after_count got=%0d want=1", cnt4); end
      exp = sb4.pop_front();
      checks++; if ({vld4, insn4, imm4, iv4} !== {1'b1, exp}) begin errors++; $display("FAIL flush_after_head got=%h want=%h", {vld4, insn4, imm4, iv4}, {1'b1, exp}); end
      rdy4 = 1'b1; @(posedge clk); #1; rdy4 = 1'b0;
   endtask

   task automatic test_back_to_back();
      sb8.push_back('{16'hC127, 16'hBEEF, 1'b1});
      beat8(8'hC1); beat8(8'h27);
      checks++; if ({busy8, cnt8} !== 4'b1_000) begin errors++; $display("FAIL opi_imm_wait got=%b want=1000", {busy8, cnt8}); end
      beat8(8'hBE); beat8(8'hEF);
      checks++; if (cnt8 !== 3'd1) begin errors++; $display("FAIL opi_count got=%0d want=1", cnt8); end
      beat8(8'h12);
      checks++; if (d8_rdy !== 1'b1) begin errors++; $display("FAIL opi_rdy got=%b want=1", d8_rdy); end
      exp = sb8.pop_front();
      checks++; if ({vld8, insn8, imm8, iv8} !== {1'b1, exp}) begin errors++; $display("FAIL opi_head got=%h want=%h", {vld8, insn8, imm8, iv8}, {1'b1, exp}); end
      sb8.push_back('{16'h1234, 16'h0000, 1'b0});
      d8 = 8'h34; d8_vld = 1'b1; rdy8 = 1'b1;
      @(posedge clk); #1;
      d8_vld = 1'b0; rdy8 = 1'b0;
      checks++; if (cnt8 !== 3'd1) begin errors++; $display("FAIL b2b_count got=%0d want=1", cnt8); end
      exp = sb8.pop_front();
      checks++; if ({vld8, insn8, imm8, iv8} !== {1'b1, exp}) begin errors++; $display("FAIL b2b_head got=%h want=%h", {vld8, insn8, imm8, iv8}, {1'b1, exp}); end
      rdy8 = 1'b1; @(posedge clk); #1; rdy8 = 1'b0;
      checks++; if ({vld8, cnt8} !== 4'b0_000) begin errors++; $display("FAIL b2b_drained got=%b want=0000", {vld8, cnt8}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_imm();
      test_uart();
      test_full();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finished");
      $fatal(1, "watchdog");
   end

endmodule
